// File: rtl/sifive_insight_tap_pkg.sv
// Shared types, widths and state encodings for the Insight data-tap capture scheduler.
// Optional record timestamp is enabled by defining SIFIVE_INSIGHT_TAP_TIMESTAMP_EN.
// Width helpers let the interface, top and bench agree on the record layout.
package sifive_insight_tap_pkg;

    // Capture state machine encoding, as seen on the state output.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } tap_state_e;

`ifdef SIFIVE_INSIGHT_TAP_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Default geometry of the block.
    localparam int DEF_N_GROUPS   = 3;
    localparam int DEF_TAP_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TS_W       = 16;

    // Group index width: max(1, clog2(n)).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Record width: data + index, plus the timestamp when that feature is built in.
    function automatic int rec_w(input int tap_w, input int n, input int ts_w);
        return tap_w + idx_w(n) + (TS_EN ? ts_w : 0);
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_N_GROUPS);

    // Record layout for the default geometry: {ts?, idx, data}, data in the LSBs.
    typedef struct packed {
`ifdef SIFIVE_INSIGHT_TAP_TIMESTAMP_EN
        logic [DEF_TS_W-1:0]  ts;
`endif
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_TAP_W-1:0] data;
    } tap_rec_t;

endpackage

// File: rtl/sifive_insight_tap_scheduler_if.sv
// Bundle of configuration, tap request/grant and record output signals.
// master = core/config/sink side, slave = the scheduler.
// Record width follows the timestamp build option (SIFIVE_INSIGHT_TAP_TIMESTAMP_EN).
interface sifive_insight_tap_scheduler_if
    import sifive_insight_tap_pkg::*;
#(
    parameter int N_GROUPS = 3,
    parameter int TAP_W    = 8,
    parameter int REC_W    = rec_w(8, 3, 16)
);
    logic                      cfg_enable;
    logic [N_GROUPS-1:0]       cfg_mask;
    logic                      trig;
    logic                      stop;
    logic [N_GROUPS-1:0]       tap_valid;
    logic [N_GROUPS*TAP_W-1:0] tap_data;
    logic [N_GROUPS-1:0]       tap_ack;
    logic                      out_valid;
    logic                      out_ready;
    logic [REC_W-1:0]          out_data;
    logic [1:0]                state;
    logic [7:0]                drop_count;

    modport master (
        output cfg_enable, cfg_mask, trig, stop, tap_valid, tap_data, out_ready,
        input  tap_ack, out_valid, out_data, state, drop_count
    );

    modport slave (
        input  cfg_enable, cfg_mask, trig, stop, tap_valid, tap_data, out_ready,
        output tap_ack, out_valid, out_data, state, drop_count
    );
endinterface

// File: rtl/sifive_insight_tap_fifo.sv
// Small synchronous record FIFO with head presented straight from storage.
// Latency: a pushed entry is visible at head the cycle after the push (no bypass).
// Backpressure: caller must not push when full unless popping in the same cycle.
module sifive_insight_tap_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the slot bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; reset discards every entry and clears the head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/sifive_insight_tap_scheduler.sv
// Round-robin capture scheduler: arbitrates tap groups into a record FIFO under an arm/trigger/stop FSM.
// Latency: tap_ack is same-cycle combinational; a granted record appears on out_data one cycle later.
// Backpressure: out_ready low fills the FIFO; then grants stop and eligible requests count as drops.
// Build option SIFIVE_INSIGHT_TAP_TIMESTAMP_EN prepends a free-running timestamp to each record.
module sifive_insight_tap_scheduler
    import sifive_insight_tap_pkg::*;
#(
    parameter int N_GROUPS   = 3,
    parameter int TAP_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 16
) (
    input logic                         clock,
    input logic                         reset,
    sifive_insight_tap_scheduler_if.slave bus
);
    localparam int IDX_W = idx_w(N_GROUPS);
    localparam int REC_W = rec_w(TAP_W, N_GROUPS, TS_W);

    tap_state_e          state_q;
    logic [IDX_W-1:0]    rr_q;
    logic [7:0]          drop_q;
    logic [N_GROUPS-1:0] req;
    logic                any_req;
    logic                found;
    logic [IDX_W:0]      cand_sum;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    grant_idx;
    logic [TAP_W-1:0]    sel_data;
    logic [N_GROUPS-1:0] ack;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                can_push;
    logic                push;
    logic [REC_W-1:0]    push_rec;
    logic [REC_W-1:0]    head_rec;

    // Requests only count while capturing.
    assign req      = (state_q == ST_CAPTURE) ? (bus.tap_valid & bus.cfg_mask) : '0;
    assign any_req  = |req;
    assign pop      = !fifo_empty && bus.out_ready;
    assign can_push = !fifo_full || pop;
    assign push     = any_req && can_push;

    // Round-robin search: first eligible group at or after rr, wrapping modulo N_GROUPS.
    always_comb begin
        found     = 1'b0;
        grant_idx = rr_q;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_GROUPS; k++) begin
            cand_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(N_GROUPS)) begin
                cand_sum = cand_sum - (IDX_W+1)'(N_GROUPS);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot ack and the granted group's data slice.
    always_comb begin
        ack      = '0;
        sel_data = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (grant_idx == IDX_W'(g)) begin
                sel_data = bus.tap_data[g*TAP_W +: TAP_W];
            end
        end
        if (push) begin
            ack[grant_idx] = 1'b1;
        end
    end

`ifdef SIFIVE_INSIGHT_TAP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign push_rec = {ts_q, grant_idx, sel_data};
`else
    assign push_rec = {grant_idx, sel_data};
`endif

    sifive_insight_tap_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_rec)
    );

    // Capture FSM; stop outranks trig because trig only matters in ARMED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_enable) state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!bus.cfg_enable) state_q <= ST_IDLE;
                    else if (bus.trig)   state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (bus.stop || !bus.cfg_enable) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Round-robin pointer advances past the winner; unchanged when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (push) begin
            rr_q <= (grant_idx == IDX_W'(N_GROUPS-1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Saturating loss counter: eligible request with no room and no pop to make room.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (any_req && !can_push && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.tap_ack    = ack;
    assign bus.out_valid  = !fifo_empty;
    // Idle output bus reads zero rather than a stale slot.
    assign bus.out_data   = fifo_empty ? '0 : head_rec;
    assign bus.state      = state_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_sifive_insight_tap_scheduler.sv
// Self-checking bench for the tap capture scheduler: directed scenarios plus a random phase,
// every cycle compared against a queue-based reference model of the scheduling rules.
// Works with or without SIFIVE_INSIGHT_TAP_TIMESTAMP_EN.
module tb_sifive_insight_tap_scheduler;
    import sifive_insight_tap_pkg::*;

    localparam int NG    = DEF_N_GROUPS;
    localparam int TW    = DEF_TAP_W;
    localparam int DEPTH = DEF_FIFO_DEPTH;
    localparam int TS    = DEF_TS_W;
    localparam int IW    = idx_w(NG);
    localparam int RW    = rec_w(TW, NG, TS);

    logic clock = 1'b0;
    logic reset = 1'b1;

    sifive_insight_tap_scheduler_if #(.N_GROUPS(NG), .TAP_W(TW), .REC_W(RW)) bus ();

    sifive_insight_tap_scheduler #(
        .N_GROUPS   (NG),
        .TAP_W      (TW),
        .FIFO_DEPTH (DEPTH),
        .TS_W       (TS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [RW-1:0] mq [$];
    int mst   = 0;
    int mrr   = 0;
    int mdrop = 0;
    int mts   = 0;

    logic [NG-1:0] last_ack;
    logic [IW-1:0] last_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst   = 0;
        mrr   = 0;
        mdrop = 0;
        mts   = 0;
    endtask

    // One clock cycle: inputs already driven; compare outputs, advance model over the edge.
    task automatic step();
        int            gsel;
        bit            popv;
        bit            canp;
        int            nst;
        logic [NG-1:0] eack;
        logic [RW-1:0] rec;
        tap_rec_t      r;
        #1;
        popv = (mq.size() > 0) && bus.out_ready;
        canp = (mq.size() < DEPTH) || popv;
        gsel = -1;
        if (mst == 2) begin
            for (int k = 0; k < NG; k++) begin
                int g;
                g = (mrr + k) % NG;
                if (gsel < 0 && bus.tap_valid[g] && bus.cfg_mask[g]) gsel = g;
            end
        end
        eack = '0;
        if (gsel >= 0 && canp) eack[gsel] = 1'b1;

        chk("tap_ack", 64'(bus.tap_ack), 64'(eack));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", 64'(bus.out_data), 64'(mq[0]));
        chk("state", 64'(bus.state), 64'(mst));
        chk("drop_count", 64'(bus.drop_count), 64'(mdrop));
        last_ack = bus.tap_ack;
        last_idx = bus.out_data[TW +: IW];

        rec = '0;
        if (gsel >= 0) begin
            r      = '0;
            r.idx  = IW'(gsel);
            r.data = bus.tap_data[gsel*TW +: TW];
`ifdef SIFIVE_INSIGHT_TAP_TIMESTAMP_EN
            r.ts   = TS'(mts);
`endif
            rec = r;
        end

        case (mst)
            0:       nst = bus.cfg_enable ? 1 : 0;
            1:       nst = !bus.cfg_enable ? 0 : (bus.trig ? 2 : 1);
            2:       nst = (bus.stop || !bus.cfg_enable) ? 3 : 2;
            default: nst = (mq.size() == 0) ? 0 : 3;
        endcase

        @(posedge clock);
        if (popv) void'(mq.pop_front());
        if (gsel >= 0 && canp) begin
            mq.push_back(rec);
            mrr = (gsel + 1) % NG;
        end else if (gsel >= 0 && mdrop < 255) begin
            mdrop++;
        end
        mst = nst;
        mts = (mts + 1) & ((1 << TS) - 1);
        @(negedge clock);
    endtask

    logic [NG-1:0] rr_seq  [5];
    int            idx_seq [4];
    int            acks;

    initial begin
        rr_seq  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        idx_seq = '{0, 1, 2, 0};

        bus.cfg_enable = 1'b0;
        bus.cfg_mask   = '0;
        bus.trig       = 1'b0;
        bus.stop       = 1'b0;
        bus.tap_valid  = '0;
        bus.tap_data   = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        #1;
        chk("rst_state", 64'(bus.state), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_drop", 64'(bus.drop_count), 64'(0));
        chk("rst_ack", 64'(bus.tap_ack), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // trig in IDLE is ignored
        bus.trig = 1'b1;
        step();
        chk("fsm_trig_idle", 64'(bus.state), 64'(0));
        bus.trig = 1'b0;
        bus.cfg_enable = 1'b1;
        step();
        chk("fsm_armed", 64'(bus.state), 64'(1));
        bus.trig = 1'b1;
        step();
        chk("fsm_capture", 64'(bus.state), 64'(2));
        bus.trig = 1'b0;

        // Round-robin fairness
        bus.cfg_mask  = 3'b111;
        bus.tap_valid = 3'b111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.tap_data = 24'($urandom);
            step();
            chk("rr_ack", 64'(last_ack), 64'(rr_seq[i]));
            if (i >= 1) chk("rr_idx", 64'(last_idx), 64'(idx_seq[i-1]));
        end

        // Mask 101: grants alternate between groups 2 and 0
        bus.cfg_mask = 3'b101;
        for (int i = 0; i < 4; i++) begin
            bus.tap_data = 24'($urandom);
            step();
            chk("mask_g1", 64'(last_ack[1]), 64'(0));
            chk("mask_ack", 64'(last_ack), (i % 2 == 0) ? 64'(3'b100) : 64'(3'b001));
        end

        // Drain, then fill with out_ready low
        bus.tap_valid = '0;
        step();
        step();
        bus.out_ready = 1'b0;
        bus.tap_valid = 3'b001;
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            bus.tap_data = 24'($urandom);
            step();
            if (last_ack != '0) acks++;
            if (i >= 4) chk("full_noack", 64'(last_ack), 64'(0));
        end
        chk("full_acks", 64'(acks), 64'(4));
        chk("drop5", 64'(bus.drop_count), 64'(5));
        for (int i = 0; i < 300; i++) step();
        chk("drop_sat", 64'(bus.drop_count), 64'(255));

        // Full with simultaneous pop: group 2 still granted
        bus.out_ready = 1'b1;
        bus.tap_valid = 3'b100;
        bus.tap_data  = 24'($urandom);
        step();
        chk("fullpop_ack", 64'(last_ack), 64'(3'b100));
        bus.out_ready = 1'b0;
        step();
        chk("fullpop_occ4", 64'(last_ack), 64'(0));
        chk("fullpop_drop", 64'(bus.drop_count), 64'(255));

        // Leave 3 records buffered, then reset mid-capture
        bus.out_ready = 1'b1;
        bus.tap_valid = '0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rstmid_state", 64'(bus.state), 64'(0));
        chk("rstmid_drop", 64'(bus.drop_count), 64'(0));
        chk("rstmid_ack", 64'(bus.tap_ack), 64'(0));
        chk("rstmid_data", 64'(bus.out_data), 64'(0));
        bus.cfg_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_stale", 64'(bus.out_valid), 64'(0));
        end

        // Stop with 2 records buffered: DRAIN, then IDLE after the FIFO empties
        bus.cfg_enable = 1'b1;
        step();
        bus.trig = 1'b1;
        step();
        bus.trig      = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_mask  = 3'b111;
        bus.tap_valid = 3'b001;
        for (int i = 0; i < 2; i++) begin
            bus.tap_data = 24'($urandom);
            step();
        end
        bus.tap_valid = '0;
        bus.stop      = 1'b1;
        step();
        chk("stop_drain", 64'(bus.state), 64'(3));
        bus.stop      = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        chk("drain_idle", 64'(bus.state), 64'(0));

        // Random phase
        for (int i = 0; i < 400; i++) begin
            bus.cfg_enable = ($urandom_range(0, 15) != 0);
            bus.trig       = ($urandom_range(0, 7) == 0);
            bus.stop       = ($urandom_range(0, 31) == 0);
            bus.cfg_mask   = NG'($urandom);
            bus.tap_valid  = NG'($urandom);
            bus.tap_data   = 24'($urandom);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
